// File: rtl/div_pkg.sv
// Shared constants for the multi-cycle divider: FSM encodings, handshake
// levels, default operand width and the latched sign-fix record.
// Optional feature macro: DIV_EARLY_OUT_EN (see rtl/div.sv).
package div_pkg;

  // FSM encodings, bit-compatible with the legacy `Div* defines
  localparam logic [1:0] DIV_FREE    = 2'b00;
  localparam logic [1:0] DIV_BY_ZERO = 2'b01;
  localparam logic [1:0] DIV_ON      = 2'b10;
  localparam logic [1:0] DIV_END     = 2'b11;

  // Handshake levels
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  // Default operand width (HI/LO register width)
  localparam int DIV_WIDTH = 32;

  // Sign corrections captured when a signed divide is accepted
  typedef struct packed {
    logic neg_quot;
    logic neg_rem;
  } div_sign_t;

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 iteration. The working register holds the partial
// remainder in the top bits and the dividend/quotient shift register below.
// A trial subtraction of the divisor decides the next quotient bit.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [2*WIDTH:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [2*WIDTH:0] dividend_o
);

  logic [WIDTH:0] diff_s;

  // Trial subtract; a borrow (MSB set) means keep the old remainder and shift in 0
  always_comb begin
    diff_s = dividend_i[2*WIDTH:WIDTH] - {1'b0, divisor_i};
    if (diff_s[WIDTH]) begin
      dividend_o = {dividend_i[2*WIDTH-1:0], 1'b0};
    end else begin
      dividend_o = {diff_s[WIDTH-1:0], dividend_i[WIDTH-1:0], 1'b1};
    end
  end

endmodule

// File: rtl/div.sv
// Multi-cycle restoring divider for DIV/DIVU. The execute stage holds
// start_i until ready_o; result_o = {remainder, quotient} goes to HI/LO.
// One quotient bit per cycle: ready_o rises WIDTH+1 edges after acceptance,
// or 2 edges for a zero divisor.
// Optional feature macro: DIV_EARLY_OUT_EN -- when defined, a divide whose
// magnitude |op1| < |op2| finishes in 2 edges with quot 0, rem = op1.
// Results are identical with or without the macro; only latency differs.
module div
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int DVD_W = 2 * WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  // Two's-complement negation at operand width
  function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  logic [1:0]         state_q,    state_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic [DVD_W-1:0]   dividend_q, dividend_d;
  logic [WIDTH-1:0]   divisor_q,  divisor_d;
  div_sign_t          sign_q,     sign_d;
  logic               early_q,    early_d;
  logic [WIDTH-1:0]   op1_q,      op1_d;
  logic [2*WIDTH-1:0] result_q,   result_d;
  logic               ready_q,    ready_d;

  logic [DVD_W-1:0]   step_out_s;
  logic [WIDTH-1:0]   mag1_s;
  logic [WIDTH-1:0]   mag2_s;
  logic               early_hit_s;
  logic [WIDTH-1:0]   quot_fix_s;
  logic [WIDTH-1:0]   rem_fix_s;
  logic               go_s;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .dividend_i(dividend_q),
    .divisor_i (divisor_q),
    .dividend_o(step_out_s)
  );

  // Operand magnitudes: absolute values for DIV, raw values for DIVU
  always_comb begin
    if (signed_div_i && opdata1_i[WIDTH-1]) begin
      mag1_s = twos_neg(opdata1_i);
    end else begin
      mag1_s = opdata1_i;
    end
    if (signed_div_i && opdata2_i[WIDTH-1]) begin
      mag2_s = twos_neg(opdata2_i);
    end else begin
      mag2_s = opdata2_i;
    end
  end

  // Early-out detection: dividend magnitude already below divisor magnitude
  always_comb begin
`ifdef DIV_EARLY_OUT_EN
    early_hit_s = (opdata2_i != {WIDTH{1'b0}}) && (mag1_s < mag2_s);
`else
    early_hit_s = 1'b0;
`endif
  end

  // Sign fix-up applied to the result of the final iteration
  always_comb begin
    if (sign_q.neg_quot) begin
      quot_fix_s = twos_neg(step_out_s[WIDTH-1:0]);
    end else begin
      quot_fix_s = step_out_s[WIDTH-1:0];
    end
    if (sign_q.neg_rem) begin
      rem_fix_s = twos_neg(step_out_s[2*WIDTH:WIDTH+1]);
    end else begin
      rem_fix_s = step_out_s[2*WIDTH:WIDTH+1];
    end
  end

  // FSM next state, iteration counter, operand latch and output registers
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    sign_d     = sign_q;
    early_d    = early_q;
    op1_d      = op1_q;
    result_d   = result_q;
    ready_d    = ready_q;
    go_s       = (start_i == DIV_START) && !annul_i;

    case (state_q)
      DIV_FREE: begin
        if (go_s) begin
          if (opdata2_i == {WIDTH{1'b0}} || early_hit_s) begin
            // Short path: zero divisor, or dividend magnitude below divisor
            state_d = DIV_BY_ZERO;
            early_d = early_hit_s;
            op1_d   = opdata1_i;
          end else begin
            state_d         = DIV_ON;
            cnt_d           = {CNT_W{1'b0}};
            dividend_d      = {{WIDTH{1'b0}}, mag1_s, 1'b0};
            divisor_d       = mag2_s;
            sign_d.neg_quot = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            sign_d.neg_rem  = signed_div_i && opdata1_i[WIDTH-1];
          end
        end else begin
          state_d = DIV_FREE;
        end
      end

      DIV_BY_ZERO: begin
        state_d = DIV_END;
        ready_d = DIV_RESULT_READY;
        if (early_q) begin
          result_d = {op1_q, {WIDTH{1'b0}}};
        end else begin
          result_d = {(2*WIDTH){1'b0}};
        end
      end

      DIV_ON: begin
        if (!go_s) begin
          state_d  = DIV_FREE;
          ready_d  = DIV_RESULT_NOT_READY;
          result_d = {(2*WIDTH){1'b0}};
        end else begin
          dividend_d = step_out_s;
          cnt_d      = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) begin
            state_d  = DIV_END;
            ready_d  = DIV_RESULT_READY;
            result_d = {rem_fix_s, quot_fix_s};
          end else begin
            state_d = DIV_ON;
          end
        end
      end

      DIV_END: begin
        // Hold the result until the requester drops start (or a flush)
        if (start_i == DIV_STOP || annul_i) begin
          state_d  = DIV_FREE;
          ready_d  = DIV_RESULT_NOT_READY;
          result_d = {(2*WIDTH){1'b0}};
        end else begin
          state_d = DIV_END;
        end
      end

      default: begin
        state_d  = DIV_FREE;
        ready_d  = DIV_RESULT_NOT_READY;
        result_d = {(2*WIDTH){1'b0}};
      end
    endcase
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= DIV_FREE;
      cnt_q      <= {CNT_W{1'b0}};
      dividend_q <= {DVD_W{1'b0}};
      divisor_q  <= {WIDTH{1'b0}};
      sign_q     <= '{neg_quot: 1'b0, neg_rem: 1'b0};
      early_q    <= 1'b0;
      op1_q      <= {WIDTH{1'b0}};
      result_q   <= {(2*WIDTH){1'b0}};
      ready_q    <= DIV_RESULT_NOT_READY;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      sign_q     <= sign_d;
      early_q    <= early_d;
      op1_q      <= op1_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule
